alu_uart_ctrl: RTL and testbench
================================

Name: alu_uart_ctrl

Overview:
Sequencer between the UART byte receiver/transmitter and the combinational ALU. Collects a 3-byte command frame (operand A, operand B, opcode) from the RX side and drives the ALU operand/opcode inputs from registers. Captures the ALU result and flags, then returns a 2-byte response (result byte, flags byte) through the TX side. A watchdog aborts partially received frames.

Parameters:
WORD_WIDTH, 8, operand/result width; must equal UART data width (8)
TIMEOUT_CYCLES, 1000000, max idle cycles between frame bytes before abort; >= 2

Ports:
i_clock  input  1  system clock, all logic on rising edge
i_reset  input  1  synchronous, active-high reset
i_rx_data  input  WORD_WIDTH  received byte, valid while i_rx_done=1
i_rx_done  input  1  one-cycle pulse: new RX byte
i_tx_done  input  1  one-cycle pulse: TX finished current byte
i_alu_result  input  WORD_WIDTH  ALU result
i_alu_flags  input  5  {exception, negative, overflow, carry, zero} from ALU
o_operand_a  output  WORD_WIDTH  registered ALU operand A
o_operand_b  output  WORD_WIDTH  registered ALU operand B
o_opcode  output  4  registered ALU opcode (low 4 bits of 3rd byte)
o_tx_data  output  WORD_WIDTH  byte to transmit, held stable until next load
o_tx_start  output  1  one-cycle pulse: start TX of o_tx_data
o_busy  output  1  high in every state except WAIT_A
o_timeout  output  1  one-cycle pulse when a partial frame is aborted

Behaviour:
- Reset (sync, i_reset=1 at rising edge): state=WAIT_A; o_operand_a, o_operand_b, o_opcode, o_tx_data, result/flags regs = 0; o_tx_start, o_busy, o_timeout = 0; watchdog = 0. Reset mid-frame or mid-transmit discards everything; no further o_tx_start.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG.
- WAIT_A: on i_rx_done, o_operand_a<=i_rx_data, ->WAIT_B. No timeout in WAIT_A.
- WAIT_B: on i_rx_done, o_operand_b<=i_rx_data, ->WAIT_OP.
- WAIT_OP: on i_rx_done, o_opcode<=i_rx_data[3:0] (upper bits ignored), ->EXEC.
- EXEC (1 cycle): ALU inputs stable; at edge capture result<=i_alu_result, flags<=i_alu_flags; ->SEND_RES.
- SEND_RES (1 cycle): o_tx_data<=result, o_tx_start=1 that cycle; ->WAIT_RES.
- WAIT_RES: on i_tx_done ->SEND_FLG.
- SEND_FLG (1 cycle): o_tx_data<={3'b000, flags}, o_tx_start=1; ->WAIT_FLG.
- WAIT_FLG: on i_tx_done ->WAIT_A.
- Latency: opcode byte rx_done at edge N -> first o_tx_start asserted in cycle N+2.
- o_tx_data is registered and loaded on entry to SEND_RES/SEND_FLG, so valid in the same cycle as o_tx_start.
- Undefined opcodes are not filtered: frame completes normally; ALU exception flag (bit 4) reported in flags byte.
- Watchdog: in WAIT_B/WAIT_OP counts cycles without i_rx_done; cleared on every accepted byte and on entering WAIT_A. On reaching TIMEOUT_CYCLES-1: ->WAIT_A, o_timeout=1 for one cycle; operand registers keep last values. i_rx_done in the same cycle as expiry wins: byte accepted, no timeout. Counter width $clog2(TIMEOUT_CYCLES); must not wrap.
- i_rx_done in EXEC/SEND_*/WAIT_RES/WAIT_FLG: byte dropped, no state effect. No timeout during TX states.
- i_tx_done outside WAIT_RES/WAIT_FLG: ignored.
- All outputs registered except o_busy (decoded from state register).

Decomposition:
- Shared package alu_pkg: opcode constants (ADD=4'b1000, SUB=4'b1010, AND=4'b1100, OR=4'b1101, XOR=4'b1110, SRA=4'b0011, SRL=4'b0010), flag bit indices (ZERO=0, CARRY=1, OVF=2, NEG=3, EXC=4), state encoding localparams.
- One sub-module: frame_watchdog (counter, clear, enable, expiry pulse), parameterised by TIMEOUT_CYCLES.

Test Plan:
- Frame 0x05,0x03,0x08 (ADD), bench ALU model -> o_operand_a=0x05, o_operand_b=0x03, o_opcode=8; TX bytes 0x08 then 0x00; o_tx_start 2 cycles after opcode rx_done.
- Frame 0x7F,0x01,0x08 -> TX 0x80 then 0x0C (negative+overflow).
- Frame 0x05,0x05,0x0A (SUB) -> TX 0x00 then 0x01 (zero); then frame 0xF0,0x3C,0x0C (AND) -> 0x30, 0x00.
- Frame 0x11,0x22,0xFF (opcode 0xF undefined) -> second TX byte has bit4=1; controller returns to WAIT_A, o_busy=0.
- TIMEOUT_CYCLES=16: send 0x01 only, idle -> o_timeout pulse exactly once, state WAIT_A; then 0x02,0x03,0x08 -> TX 0x05,0x00. Also rx_done on expiry cycle -> accepted, no pulse.
- Extra RX byte 0xAA during WAIT_RES -> dropped, response unchanged; i_reset asserted in WAIT_OP -> all outputs 0, next full frame processed correctly.

Source files
------------

// File: rtl/alu_uart_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_uart_ctrl_pkg : opcodes, flag indices and sequencer states
// Rev 1.0
// ----------------------------------------------------------------------------
package alu_uart_ctrl_pkg;

  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_SUB = 4'b1010;
  localparam logic [3:0] OP_AND = 4'b1100;
  localparam logic [3:0] OP_OR  = 4'b1101;
  localparam logic [3:0] OP_XOR = 4'b1110;
  localparam logic [3:0] OP_SRA = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0010;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_NEG   = 3;
  localparam int FLAG_EXC   = 4;
  localparam int FLAG_W     = 5;

  localparam logic [2:0] ST_WAIT_A   = 3'd0;
  localparam logic [2:0] ST_WAIT_B   = 3'd1;
  localparam logic [2:0] ST_WAIT_OP  = 3'd2;
  localparam logic [2:0] ST_EXEC     = 3'd3;
  localparam logic [2:0] ST_SEND_RES = 3'd4;
  localparam logic [2:0] ST_WAIT_RES = 3'd5;
  localparam logic [2:0] ST_SEND_FLG = 3'd6;
  localparam logic [2:0] ST_WAIT_FLG = 3'd7;

  typedef enum logic [2:0] {
    S_WAIT_A   = ST_WAIT_A,
    S_WAIT_B   = ST_WAIT_B,
    S_WAIT_OP  = ST_WAIT_OP,
    S_EXEC     = ST_EXEC,
    S_SEND_RES = ST_SEND_RES,
    S_WAIT_RES = ST_WAIT_RES,
    S_SEND_FLG = ST_SEND_FLG,
    S_WAIT_FLG = ST_WAIT_FLG
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_uart_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_uart_ctrl_if : RX/TX byte handshake plus ALU operand/result bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface alu_uart_ctrl_if #(
  parameter int WORD_WIDTH = 8
);
  import alu_uart_ctrl_pkg::*;

  logic [WORD_WIDTH-1:0] i_rx_data;
  logic                  i_rx_done;
  logic                  i_tx_done;
  logic [WORD_WIDTH-1:0] i_alu_result;
  logic [FLAG_W-1:0]     i_alu_flags;
  logic [WORD_WIDTH-1:0] o_operand_a;
  logic [WORD_WIDTH-1:0] o_operand_b;
  logic [3:0]            o_opcode;
  logic [WORD_WIDTH-1:0] o_tx_data;
  logic                  o_tx_start;
  logic                  o_busy;
  logic                  o_timeout;

  modport master (
    input  i_rx_data, i_rx_done, i_tx_done, i_alu_result, i_alu_flags,
    output o_operand_a, o_operand_b, o_opcode, o_tx_data, o_tx_start,
           o_busy, o_timeout
  );

  modport slave (
    output i_rx_data, i_rx_done, i_tx_done, i_alu_result, i_alu_flags,
    input  o_operand_a, o_operand_b, o_opcode, o_tx_data, o_tx_start,
           o_busy, o_timeout
  );
endinterface
`default_nettype wire

// File: rtl/alu_uart_ctrl_frame_watchdog.sv
`default_nettype none
// ----------------------------------------------------------------------------
// frame_watchdog : idle-cycle counter with a single-cycle expiry strobe
// Rev 1.0
// ----------------------------------------------------------------------------
module frame_watchdog #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_last  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  assign o_expired = i_enable && (r_count == c_last);

  // Restart on expiry so the counter can never wrap past the limit.
  always_ff @(posedge clk) begin
    if (rst || i_clear || o_expired) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end
endmodule
`default_nettype wire

// File: rtl/alu_uart_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_uart_ctrl : 3-byte command frame in, ALU result + flags bytes out
// Rev 1.0
// ----------------------------------------------------------------------------
module alu_uart_ctrl
  import alu_uart_ctrl_pkg::*;
#(
  parameter int WORD_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic           i_clock,
  input  logic           i_reset,
  alu_uart_ctrl_if.master bus
);
  state_t                r_state, w_next;
  logic [WORD_WIDTH-1:0] r_operand_a, r_operand_b, r_tx_data;
  logic [3:0]            r_opcode;
  logic [FLAG_W-1:0]     r_flags;
  logic                  r_tx_start, r_timeout;
  logic                  w_in_window, w_expired;

  assign w_in_window = (r_state == S_WAIT_B) || (r_state == S_WAIT_OP);

  frame_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk       (i_clock),
    .rst       (i_reset),
    .i_clear   (!w_in_window || bus.i_rx_done),
    .i_enable  (w_in_window && !bus.i_rx_done),
    .o_expired (w_expired)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT_A:   if (bus.i_rx_done) w_next = S_WAIT_B;
      S_WAIT_B:   if (bus.i_rx_done) w_next = S_WAIT_OP;
                  else if (w_expired) w_next = S_WAIT_A;
      S_WAIT_OP:  if (bus.i_rx_done) w_next = S_EXEC;
                  else if (w_expired) w_next = S_WAIT_A;
      S_EXEC:     w_next = S_SEND_RES;
      S_SEND_RES: w_next = S_WAIT_RES;
      S_WAIT_RES: if (bus.i_tx_done) w_next = S_SEND_FLG;
      S_SEND_FLG: w_next = S_WAIT_FLG;
      S_WAIT_FLG: if (bus.i_tx_done) w_next = S_WAIT_A;
      default:    w_next = S_WAIT_A;
    endcase
  end

  // The result byte lives in r_tx_data: it is loaded straight from the ALU
  // on the EXEC edge so it is valid alongside the first tx_start.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_WAIT_A;
      r_operand_a <= '0;
      r_operand_b <= '0;
      r_opcode    <= '0;
      r_tx_data   <= '0;
      r_flags     <= '0;
      r_tx_start  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_tx_start <= 1'b0;
      r_timeout  <= w_in_window && w_expired;
      case (r_state)
        S_WAIT_A:  if (bus.i_rx_done) r_operand_a <= bus.i_rx_data;
        S_WAIT_B:  if (bus.i_rx_done) r_operand_b <= bus.i_rx_data;
        S_WAIT_OP: if (bus.i_rx_done) r_opcode <= bus.i_rx_data[3:0];
        S_EXEC: begin
          r_tx_data  <= bus.i_alu_result;
          r_flags    <= bus.i_alu_flags;
          r_tx_start <= 1'b1;
        end
        S_WAIT_RES: if (bus.i_tx_done) begin
          r_tx_data  <= WORD_WIDTH'({3'b000, r_flags});
          r_tx_start <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_operand_a = r_operand_a;
  assign bus.o_operand_b = r_operand_b;
  assign bus.o_opcode    = r_opcode;
  assign bus.o_tx_data   = r_tx_data;
  assign bus.o_tx_start  = r_tx_start;
  assign bus.o_timeout   = r_timeout;
  assign bus.o_busy      = (r_state != S_WAIT_A);
endmodule
`default_nettype wire

// File: tb/tb_alu_uart_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alu_uart_ctrl : frame table plus timeout/reset/drop sequences
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_alu_uart_ctrl;
  import alu_uart_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_uart_ctrl_if #(.WORD_WIDTH(8)) bus ();

  alu_uart_ctrl #(.WORD_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // Reference ALU: carry on SUB means borrow; unknown opcodes raise exception.
  always_comb begin
    logic [8:0] w_s;
    logic [7:0] a, b, r;
    logic       c, v, e;
    a = bus.o_operand_a; b = bus.o_operand_b;
    w_s = '0; r = '0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (bus.o_opcode)
      OP_ADD: begin w_s = {1'b0, a} + {1'b0, b}; r = w_s[7:0]; c = w_s[8];
                    v = (a[7] == b[7]) && (r[7] != a[7]); end
      OP_SUB: begin r = a - b; c = (a < b); v = (a[7] != b[7]) && (r[7] != a[7]); end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_SRA: r = $signed(a) >>> b[2:0];
      OP_SRL: r = a >> b[2:0];
      default: e = 1'b1;
    endcase
    bus.i_alu_result = r;
    bus.i_alu_flags  = {e, r[7], v, c, (r == 8'h00)};
  end

  typedef struct {
    logic [7:0] a, b, op, res, flg;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    bus.i_rx_data = d; bus.i_rx_done = 1'b1;
    tick();
    bus.i_rx_done = 1'b0;
  endtask

  task automatic respond(input logic [7:0] a, b, op, res, flg, input bit extra);
    send_byte(op);
    chk("start_early", bus.o_tx_start, 0);
    tick();
    chk("start_n2", bus.o_tx_start, 1);
    chk("res_byte", bus.o_tx_data, res);
    chk("opnd_a", bus.o_operand_a, a);
    chk("opnd_b", bus.o_operand_b, b);
    chk("opcode", bus.o_opcode, op[3:0]);
    tick();
    chk("start_pulse", bus.o_tx_start, 0);
    chk("busy_wait_res", bus.o_busy, 1);
    if (extra) send_byte(8'hAA);
    tick(); tick();
    bus.i_tx_done = 1'b1; tick(); bus.i_tx_done = 1'b0;
    chk("start_flg", bus.o_tx_start, 1);
    chk("flg_byte", bus.o_tx_data, flg);
    tick();
    bus.i_tx_done = 1'b1; tick(); bus.i_tx_done = 1'b0;
    chk("busy_idle", bus.o_busy, 0);
    chk("opnd_a_kept", bus.o_operand_a, a);
  endtask

  task automatic run_frame(input logic [7:0] a, b, op, res, flg, input bit extra);
    send_byte(a);
    send_byte(b);
    respond(a, b, op, res, flg, extra);
  endtask

  initial begin
    int first, pulses;
    vecs[0] = '{8'h05, 8'h03, 8'h08, 8'h08, 8'h00};
    vecs[1] = '{8'h7F, 8'h01, 8'h08, 8'h80, 8'h0C};
    vecs[2] = '{8'h05, 8'h05, 8'h0A, 8'h00, 8'h01};
    vecs[3] = '{8'hF0, 8'h3C, 8'h0C, 8'h30, 8'h00};
    vecs[4] = '{8'h11, 8'h22, 8'hFF, 8'h00, 8'h11};
    vecs[5] = '{8'h80, 8'h01, 8'h0D, 8'h81, 8'h08};

    bus.i_rx_data = '0; bus.i_rx_done = 1'b0; bus.i_tx_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_txdata", bus.o_tx_data, 0);
    chk("rst_opnd_a", bus.o_operand_a, 0);
    chk("rst_start", bus.o_tx_start, 0);

    foreach (vecs[i])
      run_frame(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].flg, 1'b0);

    // Stray RX byte while waiting for TX completion.
    run_frame(8'h05, 8'h03, 8'h08, 8'h08, 8'h00, 1'b1);

    // Reset while waiting for the opcode byte.
    send_byte(8'h44); send_byte(8'h55);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_busy", bus.o_busy, 0);
    chk("mid_rst_a", bus.o_operand_a, 0);
    chk("mid_rst_b", bus.o_operand_b, 0);
    chk("mid_rst_op", bus.o_opcode, 0);
    chk("mid_rst_start", bus.o_tx_start, 0);
    run_frame(8'h02, 8'h03, 8'h08, 8'h05, 8'h00, 1'b0);

    // Partial frame left idle: exactly one timeout after 16 idle cycles.
    send_byte(8'h01);
    first = 0; pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.o_timeout === 1'b1) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    chk("to_pulses", pulses, 1);
    chk("to_cycle", first, 16);
    chk("to_busy", bus.o_busy, 0);
    chk("to_opnd_a", bus.o_operand_a, 8'h01);
    run_frame(8'h02, 8'h03, 8'h08, 8'h05, 8'h00, 1'b0);

    // Byte arriving on the expiry cycle is accepted instead.
    send_byte(8'h01);
    repeat (15) tick();
    send_byte(8'h02);
    chk("exp_no_to", bus.o_timeout, 0);
    chk("exp_busy", bus.o_busy, 1);
    chk("exp_opnd_b", bus.o_operand_b, 8'h02);
    respond(8'h01, 8'h02, 8'h08, 8'h03, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
